recovery_sequencer: RTL
=======================

# recovery_sequencer

Fault-recovery controller sitting between the lockstep error comparator and the core register files. On a detected error it halts the cores, waits for pipeline drain, then sweeps the architectural registers, copying each from the golden register-file copy into the faulty copy through a one-cycle-latency read/write pipeline. Errors during the sweep restart it, and too many retries latch a permanent failure.

## Interface
- ADDR_WIDTH, 5: register address width; NUM_REG = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: register data width.
- SKIP_ZERO, 1: 1 = register 0 is hardwired and not copied; sweep starts at FIRST = SKIP_ZERO.
- MAX_RETRY, 3: sweep restarts allowed per recovery before failure.

Ports (reset is synchronous, active-high; single clock):
- clk  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- error_i  in  1  comparator mismatch, level or pulse, sampled every cycle.
- halt_o  out  1  stall request to both cores.
- halt_ack_i  in  1  cores drained and stalled.
- rf_rd_addr_o  out  ADDR_WIDTH  golden-copy read address.
- rf_rd_data_i  in  DATA_WIDTH  golden-copy data, valid one cycle after address.
- rf_we_o  out  1  faulty-copy write enable.
- rf_wr_addr_o  out  ADDR_WIDTH  write address.
- rf_wr_data_o  out  DATA_WIDTH  write data.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse on recovery completion.
- fail_o  out  1  sticky unrecoverable flag.
- recov_count_o  out  8  saturating count of recoveries started from IDLE.

## Operation
- States: IDLE, DRAIN, COPY, FLUSH, DONE, FAIL.
- IDLE: error_i=1 -> DRAIN, retry counter cleared, recov_count_o += 1 (saturates at 255).
- DRAIN: halt_o=1; error_i ignored; halt_ack_i=1 -> COPY with sweep address = FIRST.
- COPY: each cycle rf_rd_addr_o = sweep address, address += 1. Write stage registered: next cycle rf_we_o=1, rf_wr_addr_o = previous read address, rf_wr_data_o = rf_rd_data_i. When address NUM_REG-1 is issued -> FLUSH.
- Sweep counter is ADDR_WIDTH+1 bits, or the terminal compare is against all-ones; the address must never wrap to 0 mid-sweep.
- FLUSH: final write only, no read -> DONE.
- DONE: done_o=1, halt_o=0, rf_we_o=0 -> IDLE. If error_i=1 in DONE, done_o still pulses and the next state is DRAIN (new recovery, counter +1).
- error_i=1 in COPY or FLUSH:
  - retry < MAX_RETRY: retry += 1, pending write dropped (rf_we_o=0 next cycle), restart COPY at FIRST. halt_o stays 1; no re-drain.
  - retry == MAX_RETRY: go to FAIL.
- FAIL: halt_o=1, fail_o=1, rf_we_o=0; exits only on rst_i.
- rst_i (any state, including mid-sweep): next cycle IDLE.
  - Reset values: halt_o=0, rf_we_o=0, rf_rd_addr_o=0, rf_wr_addr_o=0, rf_wr_data_o=0, busy_o=0, done_o=0, fail_o=0, recov_count_o=0.
  - An in-flight write is abandoned.

## Timing
- error_i sampled high at cycle t in IDLE -> halt_o=1, busy_o=1 at t+1.
- halt_ack_i high at cycle d in DRAIN -> first read (addr FIRST) at d+1.
- Read at cycle c -> write of same address at c+1. Each cycle issues at most one read and one write.
- Sweep length R = NUM_REG - FIRST reads (31 at defaults).
- COPY lasts R cycles, FLUSH 1, DONE 1. done_o at d+R+2; halt_o low from that cycle.
- Error-free recovery latency, error sample to done_o: (d - t) + R + 2 cycles.
- Restart: error in COPY cycle c -> read of FIRST at c+1, rf_we_o=0 at c+1.

## Structure
- Package ft_ctrl_pkg:
  - state enum rec_state_t;
  - NUM_REG computation;
  - recov_count_o width constant (8).
- One natural sub-module: sweep_counter.
  - Inputs: start and advance.
  - Outputs: address and last flag.
  - Parameters: ADDR_WIDTH and FIRST.
- FSM, retry counter, write-stage registers and statistics stay in recovery_sequencer.

## Test plan
- Nominal (defaults, golden reg i = 0xA000_0000+i): error pulse, halt_ack_i 3 cycles later -> writes to addrs 1..31 with matching data, one per cycle, no write to 0, done_o exactly once, halt_o low after, recov_count_o=1.
- SKIP_ZERO=0, ADDR_WIDTH=2 -> writes 0,1,2,3 then done_o. Address never wraps; no 5th write.
- Error at 10th read -> that read's write suppressed, sweep restarts at 1, full 31 writes follow, done_o once.
- MAX_RETRY=3 with four errors during COPY -> FAIL. fail_o=1, halt_o=1, no further writes; persists until rst_i, after which all outputs are 0.
- rst_i mid-COPY -> next cycle IDLE, rf_we_o=0, halt_o=0. A following error starts a fresh sweep at FIRST.
- error_i held high through DONE -> done_o pulses, then DRAIN, recov_count_o=2. 300 recoveries -> recov_count_o=255.

Source files
------------

// File: rtl/recovery_sequencer_pkg.sv
// Shared types and helpers for the lockstep fault-recovery controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COPY,
    ST_FLUSH,
    ST_DONE,
    ST_FAIL
  } rec_state_t;

  // Width of the saturating recovery statistics counter.
  localparam int REC_CNT_W = 8;

  function automatic int num_reg(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/recovery_sequencer_if.sv
// Halt handshake plus golden-read / faulty-write register-file port.
// Latency: n/a (signal bundle); golden read data is expected one cycle after address.
// Backpressure: halt_ack_i is the only flow control; the register-file port never stalls.
// master = recovery_sequencer, slave = cores / register-file side.
interface recovery_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  error_i;
  logic                  halt_o;
  logic                  halt_ack_i;
  logic [ADDR_WIDTH-1:0] rf_rd_addr_o;
  logic [DATA_WIDTH-1:0] rf_rd_data_i;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_o;
  logic [DATA_WIDTH-1:0] rf_wr_data_o;

  modport master (
    input  error_i, halt_ack_i, rf_rd_data_i,
    output halt_o, rf_rd_addr_o, rf_we_o, rf_wr_addr_o, rf_wr_data_o
  );

  modport slave (
    output error_i, halt_ack_i, rf_rd_data_i,
    input  halt_o, rf_rd_addr_o, rf_we_o, rf_wr_addr_o, rf_wr_data_o
  );
endinterface

// File: rtl/recovery_sequencer_sweep_counter.sv
// Sweep address generator: loads FIRST on start, steps on advance, flags the top register.
// Latency: address updates one cycle after start/advance.
// Backpressure: holds its value whenever advance is low.
// Ports: clk, rst_i, i_start, i_advance -> o_addr, o_last.
module sweep_counter
  import ft_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int FIRST      = 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  i_start,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);

  // Terminal compare against all-ones: the counter is never advanced past the
  // top register, so it cannot wrap back to 0 mid-sweep.
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(num_reg(ADDR_WIDTH) - 1);

  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_addr <= '0;
    end else if (i_start) begin
      r_addr <= ADDR_WIDTH'(FIRST);
    end else if (i_advance) begin
      r_addr <= r_addr + ADDR_WIDTH'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_addr == LAST);

endmodule

// File: rtl/recovery_sequencer.sv
// Halts the lockstep cores on an error and copies golden registers into the faulty copy.
// Latency: error -> halt 1 cycle; ack -> first read 1 cycle; read -> write 1 cycle.
// Backpressure: waits indefinitely in DRAIN for halt_ack_i; the sweep itself never stalls.
// Ports: clk, rst_i, bus (master modport), busy_o, done_o, fail_o, recov_count_o.
module recovery_sequencer
  import ft_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SKIP_ZERO  = 1,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  rst_i,
  recovery_sequencer_if.master  bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [REC_CNT_W-1:0]  recov_count_o
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  rec_state_t            r_state;
  logic [RW-1:0]         r_retry;
  logic                  r_halt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fail;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [REC_CNT_W-1:0]  r_count;

  logic                  w_sweeping;
  logic                  w_can_retry;
  logic                  w_start;
  logic                  w_advance;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_sweeping  = (r_state == ST_COPY) || (r_state == ST_FLUSH);
  assign w_can_retry = (r_retry < RW'(MAX_RETRY));
  // Restart from FIRST on drain completion or on a retryable mid-sweep error.
  assign w_start     = ((r_state == ST_DRAIN) && bus.halt_ack_i) ||
                       (w_sweeping && bus.error_i && w_can_retry);
  // Stop stepping once the top register has been issued.
  assign w_advance   = (r_state == ST_COPY) && !bus.error_i && !w_last;

  sweep_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .FIRST      (SKIP_ZERO)
  ) u_sweep (
    .clk       (clk),
    .rst_i     (rst_i),
    .i_start   (w_start),
    .i_advance (w_advance),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_retry   <= '0;
      r_halt    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_we      <= 1'b0;
      r_wr_addr <= '0;
      r_count   <= '0;
    end else begin
      r_done    <= 1'b0;
      // Write stage: a read issued this cycle is written next cycle unless an
      // error arrives now, which drops it (restart or failure).
      r_we      <= (r_state == ST_COPY) && !bus.error_i;
      r_wr_addr <= w_addr;
      case (r_state)
        ST_IDLE: begin
          if (bus.error_i) begin
            r_state <= ST_DRAIN;
            r_halt  <= 1'b1;
            r_busy  <= 1'b1;
            r_retry <= '0;
            if (r_count != {REC_CNT_W{1'b1}}) r_count <= r_count + REC_CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (bus.halt_ack_i) r_state <= ST_COPY;
        end
        ST_COPY, ST_FLUSH: begin
          if (bus.error_i) begin
            if (w_can_retry) begin
              r_retry <= r_retry + RW'(1);
              r_state <= ST_COPY;
            end else begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end
          end else if (r_state == ST_FLUSH) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_halt  <= 1'b0;
          end else if (w_last) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_DONE: begin
          // An error here starts a fresh recovery straight away.
          if (bus.error_i) begin
            r_state <= ST_DRAIN;
            r_halt  <= 1'b1;
            r_retry <= '0;
            if (r_count != {REC_CNT_W{1'b1}}) r_count <= r_count + REC_CNT_W'(1);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_FAIL: begin
          r_state <= ST_FAIL;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.halt_o       = r_halt;
  assign bus.rf_rd_addr_o = w_addr;
  assign bus.rf_we_o      = r_we;
  assign bus.rf_wr_addr_o = r_wr_addr;
  // Golden data arrives the cycle after its read, i.e. in the write cycle.
  assign bus.rf_wr_data_o = r_we ? bus.rf_rd_data_i : '0;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign fail_o           = r_fail;
  assign recov_count_o    = r_count;

endmodule
